mac_lut_age_arbiter: RTL and testbench

- Sits between op_lut_regs and mac_cam_lut in the learning CAM switch output_port_lookup.
- Shares the single LUT direct-access read/write port between software register requests and an internal ageing engine.
- The ageing engine periodically scans every entry and invalidates unprotected entries that have had no lookup hit for MAX_AGE scan periods.
- Software always has priority; ageing uses idle port slots only.

---
 rtl/mac_lut_age_arbiter_pkg.sv | 23 ++
 rtl/mac_lut_age_arbiter_age_table.sv | 40 ++++
 rtl/mac_lut_age_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mac_lut_age_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_lut_age_arbiter_pkg.sv
// Shared constants and FSM encoding for the LUT port arbiter and ageing engine.
package mac_lut_age_arbiter_pkg;

  localparam int MAC_W        = 48;
  localparam int AGE_BITS_DEF = 3;

  // state      | meaning
  // ST_IDLE    | port free, pick next owner
  // ST_SW_RD   | software read owns the LUT read port
  // ST_SW_WR   | software write owns the LUT write port
  // ST_AGE_RD  | ageing read of scan_ptr entry
  // ST_AGE_WR  | ageing invalidation write of scan_ptr entry
  // ST_AGE_REL | ageing releases the port, advances scan_ptr
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_SW_RD   = 6'b000010,
    ST_SW_WR   = 6'b000100,
    ST_AGE_RD  = 6'b001000,
    ST_AGE_WR  = 6'b010000,
    ST_AGE_REL = 6'b100000
  } state_t;

endpackage

// File: rtl/mac_lut_age_arbiter_age_table.sv
// Per-entry saturating age counters; any clear beats an increment to the same entry.
module mac_lut_age_arbiter_age_table
  import mac_lut_age_arbiter_pkg::*;
#(
  parameter int DEPTH_BITS = 4,
  parameter int AGE_BITS   = AGE_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_a,
  input  logic [DEPTH_BITS-1:0] clr_a_idx,
  input  logic                  clr_b,
  input  logic [DEPTH_BITS-1:0] clr_b_idx,
  input  logic                  inc,
  input  logic [DEPTH_BITS-1:0] inc_idx,
  input  logic [DEPTH_BITS-1:0] rd_idx,
  output logic [AGE_BITS-1:0]   rd_age
);

  localparam int                  DEPTH   = 1 << DEPTH_BITS;
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  logic [AGE_BITS-1:0] age_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((clr_a && clr_a_idx == DEPTH_BITS'(i)) || (clr_b && clr_b_idx == DEPTH_BITS'(i)))
          age_q[i] <= '0;
        else if (inc && inc_idx == DEPTH_BITS'(i) && age_q[i] != AGE_MAX)
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  assign rd_age = age_q[rd_idx];

endmodule

// File: rtl/mac_lut_age_arbiter.sv
// Shares the LUT direct-access port between software and a background ageing scan.
module mac_lut_age_arbiter
  import mac_lut_age_arbiter_pkg::*;
#(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int LUT_DEPTH_BITS    = 4,
  parameter int AGE_BITS          = AGE_BITS_DEF,
  parameter int TICK_CYCLES       = 125000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LUT_DEPTH_BITS-1:0]    sw_rd_addr,
  input  logic                         sw_rd_req,
  output logic [NUM_OUTPUT_QUEUES-1:0] sw_rd_oq,
  output logic                         sw_rd_wr_protect,
  output logic [MAC_W-1:0]             sw_rd_mac,
  output logic                         sw_rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0]    sw_wr_addr,
  input  logic                         sw_wr_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0] sw_wr_oq,
  input  logic                         sw_wr_protect,
  input  logic [MAC_W-1:0]             sw_wr_mac,
  output logic                         sw_wr_ack,
  output logic [LUT_DEPTH_BITS-1:0]    lut_rd_addr,
  output logic                         lut_rd_req,
  output logic [LUT_DEPTH_BITS-1:0]    lut_wr_addr,
  output logic                         lut_wr_req,
  output logic [NUM_OUTPUT_QUEUES-1:0] lut_wr_oq,
  output logic                         lut_wr_protect,
  output logic [MAC_W-1:0]             lut_wr_mac,
  input  logic [NUM_OUTPUT_QUEUES-1:0] lut_rd_oq,
  input  logic                         lut_rd_wr_protect,
  input  logic [MAC_W-1:0]             lut_rd_mac,
  input  logic                         lut_rd_ack,
  input  logic                         lut_wr_ack,
  input  logic                         lut_hit,
  input  logic [LUT_DEPTH_BITS-1:0]    lut_hit_addr,
  input  logic                         aging_en,
  output logic [31:0]                  entries_aged
);

  localparam logic [31:0]               TICK_LAST = 32'(TICK_CYCLES - 1);
  localparam logic [LUT_DEPTH_BITS-1:0] LAST_IDX  = '1;
  localparam logic [AGE_BITS-1:0]       AGE_MAX   = '1;

  state_t                         state_q, state_d;
  logic [31:0]                    tick_cnt_q;
  logic                           scan_pending_q;
  logic [LUT_DEPTH_BITS-1:0]      scan_ptr_q;
  logic                           tick;

  logic                           rd_req_d, wr_req_d, wr_prot_d;
  logic [LUT_DEPTH_BITS-1:0]      rd_addr_d, wr_addr_d;
  logic [NUM_OUTPUT_QUEUES-1:0]   wr_oq_d;
  logic [MAC_W-1:0]               wr_mac_d;
  logic                           sw_wr_done, age_wr_done, age_inc, ptr_adv, hit_at_ptr;
  logic [AGE_BITS-1:0]            age_cur;

  assign tick       = aging_en && (tick_cnt_q == TICK_LAST);
  assign hit_at_ptr = lut_hit && (lut_hit_addr == scan_ptr_q);

  assign sw_rd_ack        = (state_q == ST_SW_RD) && lut_rd_ack;
  assign sw_rd_oq         = (state_q == ST_SW_RD) ? lut_rd_oq : '0;
  assign sw_rd_wr_protect = (state_q == ST_SW_RD) && lut_rd_wr_protect;
  assign sw_rd_mac        = (state_q == ST_SW_RD) ? lut_rd_mac : '0;
  assign sw_wr_ack        = (state_q == ST_SW_WR) && lut_wr_ack;

  always_comb begin
    state_d     = state_q;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    rd_addr_d   = lut_rd_addr;
    wr_addr_d   = lut_wr_addr;
    wr_oq_d     = lut_wr_oq;
    wr_prot_d   = lut_wr_protect;
    wr_mac_d    = lut_wr_mac;
    sw_wr_done  = 1'b0;
    age_wr_done = 1'b0;
    age_inc     = 1'b0;
    ptr_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sw_wr_req) begin
          state_d   = ST_SW_WR;
          wr_req_d  = 1'b1;
          wr_addr_d = sw_wr_addr;
          wr_oq_d   = sw_wr_oq;
          wr_prot_d = sw_wr_protect;
          wr_mac_d  = sw_wr_mac;
        end else if (sw_rd_req) begin
          state_d   = ST_SW_RD;
          rd_req_d  = 1'b1;
          rd_addr_d = sw_rd_addr;
        end else if (scan_pending_q && aging_en) begin
          state_d   = ST_AGE_RD;
          rd_req_d  = 1'b1;
          rd_addr_d = scan_ptr_q;
        end
      end
      ST_SW_RD: begin
        rd_req_d = sw_rd_req;
        if (sw_rd_req) rd_addr_d = sw_rd_addr;
        if (!sw_rd_req && !lut_rd_ack) state_d = ST_IDLE;
      end
      ST_SW_WR: begin
        wr_req_d = sw_wr_req;
        // Latch data only while req is held so the completed address is stable for the age clear.
        if (sw_wr_req) begin
          wr_addr_d = sw_wr_addr;
          wr_oq_d   = sw_wr_oq;
          wr_prot_d = sw_wr_protect;
          wr_mac_d  = sw_wr_mac;
        end
        if (!sw_wr_req && !lut_wr_ack) begin
          state_d    = ST_IDLE;
          sw_wr_done = 1'b1;
        end
      end
      ST_AGE_RD: begin
        rd_req_d = 1'b1;
        if (lut_rd_ack) begin
          rd_req_d = 1'b0;
          if (age_cur == AGE_MAX && !lut_rd_wr_protect && lut_rd_mac != '0 && !hit_at_ptr) begin
            state_d   = ST_AGE_WR;
            wr_req_d  = 1'b1;
            wr_addr_d = scan_ptr_q;
            wr_oq_d   = '0;
            wr_prot_d = 1'b0;
            wr_mac_d  = '0;
          end else begin
            state_d = ST_AGE_REL;
            age_inc = 1'b1;
          end
        end
      end
      ST_AGE_WR: begin
        wr_req_d = 1'b1;
        if (lut_wr_ack) begin
          wr_req_d    = 1'b0;
          age_wr_done = 1'b1;
          state_d     = ST_AGE_REL;
        end
      end
      ST_AGE_REL: begin
        if (!lut_rd_ack && !lut_wr_ack) begin
          ptr_adv = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lut_rd_req     <= 1'b0;
      lut_wr_req     <= 1'b0;
      lut_rd_addr    <= '0;
      lut_wr_addr    <= '0;
      lut_wr_oq      <= '0;
      lut_wr_protect <= 1'b0;
      lut_wr_mac     <= '0;
      tick_cnt_q     <= '0;
      scan_pending_q <= 1'b0;
      scan_ptr_q     <= '0;
      entries_aged   <= '0;
    end else begin
      state_q        <= state_d;
      lut_rd_req     <= rd_req_d;
      lut_wr_req     <= wr_req_d;
      lut_rd_addr    <= rd_addr_d;
      lut_wr_addr    <= wr_addr_d;
      lut_wr_oq      <= wr_oq_d;
      lut_wr_protect <= wr_prot_d;
      lut_wr_mac     <= wr_mac_d;

      if (!aging_en || tick) tick_cnt_q <= '0;
      else                   tick_cnt_q <= tick_cnt_q + 32'd1;

      // A tick arriving while a scan is still pending is dropped.
      if (!aging_en)                               scan_pending_q <= 1'b0;
      else if (tick && !scan_pending_q)            scan_pending_q <= 1'b1;
      else if (ptr_adv && scan_ptr_q == LAST_IDX)  scan_pending_q <= 1'b0;

      if (ptr_adv)     scan_ptr_q   <= scan_ptr_q + 1'b1;
      if (age_wr_done) entries_aged <= entries_aged + 32'd1;
    end
  end

  mac_lut_age_arbiter_age_table #(
    .DEPTH_BITS (LUT_DEPTH_BITS),
    .AGE_BITS   (AGE_BITS)
  ) u_age_table (
    .clk       (clk),
    .reset     (reset),
    .clr_a     (sw_wr_done || age_wr_done),
    .clr_a_idx (lut_wr_addr),
    .clr_b     (lut_hit),
    .clr_b_idx (lut_hit_addr),
    .inc       (age_inc),
    .inc_idx   (scan_ptr_q),
    .rd_idx    (scan_ptr_q),
    .rd_age    (age_cur)
  );

endmodule

// File: tb/tb_mac_lut_age_arbiter.sv
// Scoreboard bench: directed software/ageing scenarios against a behavioural LUT.
module tb_mac_lut_age_arbiter;
  localparam int NQ = 8;
  localparam int DB = 4;
  localparam int TC = 16;
  localparam logic [47:0] MAC5 = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] MAC3 = 48'h112233445566;

  logic clk = 1'b0;
  logic reset, mem_init;
  logic [DB-1:0] sw_rd_addr, sw_wr_addr, lut_rd_addr, lut_wr_addr, lut_hit_addr;
  logic sw_rd_req, sw_rd_wr_protect, sw_rd_ack, sw_wr_req, sw_wr_protect, sw_wr_ack;
  logic [NQ-1:0] sw_rd_oq, sw_wr_oq, lut_wr_oq, lut_rd_oq;
  logic [47:0] sw_rd_mac, sw_wr_mac, lut_wr_mac, lut_rd_mac;
  logic lut_rd_req, lut_wr_req, lut_wr_protect, lut_rd_wr_protect;
  logic lut_rd_ack, lut_wr_ack, lut_hit, aging_en;
  logic [31:0] entries_aged;

  always #5 clk = ~clk;

  mac_lut_age_arbiter #(.NUM_OUTPUT_QUEUES(NQ), .LUT_DEPTH_BITS(DB), .AGE_BITS(3), .TICK_CYCLES(TC)) dut (
    .clk(clk), .reset(reset),
    .sw_rd_addr(sw_rd_addr), .sw_rd_req(sw_rd_req), .sw_rd_oq(sw_rd_oq),
    .sw_rd_wr_protect(sw_rd_wr_protect), .sw_rd_mac(sw_rd_mac), .sw_rd_ack(sw_rd_ack),
    .sw_wr_addr(sw_wr_addr), .sw_wr_req(sw_wr_req), .sw_wr_oq(sw_wr_oq),
    .sw_wr_protect(sw_wr_protect), .sw_wr_mac(sw_wr_mac), .sw_wr_ack(sw_wr_ack),
    .lut_rd_addr(lut_rd_addr), .lut_rd_req(lut_rd_req), .lut_wr_addr(lut_wr_addr),
    .lut_wr_req(lut_wr_req), .lut_wr_oq(lut_wr_oq), .lut_wr_protect(lut_wr_protect),
    .lut_wr_mac(lut_wr_mac), .lut_rd_oq(lut_rd_oq), .lut_rd_wr_protect(lut_rd_wr_protect),
    .lut_rd_mac(lut_rd_mac), .lut_rd_ack(lut_rd_ack), .lut_wr_ack(lut_wr_ack),
    .lut_hit(lut_hit), .lut_hit_addr(lut_hit_addr), .aging_en(aging_en),
    .entries_aged(entries_aged)
  );

  // Behavioural LUT: ack follows req by one cycle, write lands on the first req cycle.
  typedef struct packed { logic [NQ-1:0] oq; logic prot; logic [47:0] mac; } ent_t;
  ent_t lut_mem [16];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) lut_mem[i] <= '0;
      lut_mem[3] <= '{oq: 8'h5A, prot: 1'b1, mac: MAC3};
      lut_rd_ack <= 1'b0;
      lut_wr_ack <= 1'b0;
    end else begin
      lut_rd_ack <= lut_rd_req;
      lut_wr_ack <= lut_wr_req;
      if (lut_wr_req && !lut_wr_ack)
        lut_mem[lut_wr_addr] <= '{oq: lut_wr_oq, prot: lut_wr_protect, mac: lut_wr_mac};
    end
  end

  assign lut_rd_oq         = lut_mem[lut_rd_addr].oq;
  assign lut_rd_wr_protect = lut_mem[lut_rd_addr].prot;
  assign lut_rd_mac        = lut_mem[lut_rd_addr].mac;

  typedef struct { bit is_wr; logic [DB-1:0] addr; logic [47:0] mac; logic [NQ-1:0] oq; logic prot; } exp_t;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int age_rd_cnt = 0;
  int rd5_cnt = 0;
  logic [DB-1:0] last_age_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input bit w, input logic [DB-1:0] a, input logic [47:0] m, input logic [NQ-1:0] q, input logic p);
    exp_t e;
    e.is_wr = w; e.addr = a; e.mac = m; e.oq = q; e.prot = p;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation for every LUT write start and every software read ack.
  initial begin
    logic prev_wr, prev_rd, prev_ack;
    exp_t e;
    prev_wr = 0; prev_rd = 0; prev_ack = 0;
    forever begin
      @(negedge clk);
      if (lut_wr_req === 1'b1 && !prev_wr) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr=%0d mac=%0h, expected no write", lut_wr_addr, lut_wr_mac);
        end else begin
          e = exp_q.pop_front();
          check("wr_kind", 64'(lut_wr_req), 64'(e.is_wr));
          check("wr_addr", 64'(lut_wr_addr), 64'(e.addr));
          check("wr_mac", 64'(lut_wr_mac), 64'(e.mac));
          check("wr_oq", 64'(lut_wr_oq), 64'(e.oq));
          check("wr_prot", 64'(lut_wr_protect), 64'(e.prot));
        end
      end
      if (sw_rd_ack === 1'b1 && !prev_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read_ack: got mac=%0h, expected none", sw_rd_mac);
        end else begin
          e = exp_q.pop_front();
          check("rd_kind", 64'(!e.is_wr), 64'd1);
          check("rd_addr", 64'(lut_rd_addr), 64'(e.addr));
          check("rd_mac", 64'(sw_rd_mac), 64'(e.mac));
          check("rd_oq", 64'(sw_rd_oq), 64'(e.oq));
          check("rd_prot", 64'(sw_rd_wr_protect), 64'(e.prot));
        end
      end
      if (lut_rd_req === 1'b1 && !prev_rd && !sw_rd_req) begin
        age_rd_cnt++;
        last_age_addr = lut_rd_addr;
        if (lut_rd_addr == 4'd5) rd5_cnt++;
      end
      prev_wr = (lut_wr_req === 1'b1);
      prev_rd = (lut_rd_req === 1'b1);
      prev_ack = (sw_rd_ack === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_wr_ack(input logic lvl);
    for (int i = 0; i < 100 && sw_wr_ack !== lvl; i++) tick();
    if (sw_wr_ack !== lvl) begin
      checks++; errors++;
      $display("FAIL sw_wr_ack_timeout: got %b expected %b", sw_wr_ack, lvl);
    end
  endtask

  task automatic wait_rd_ack(input logic lvl);
    for (int i = 0; i < 100 && sw_rd_ack !== lvl; i++) tick();
    if (sw_rd_ack !== lvl) begin
      checks++; errors++;
      $display("FAIL sw_rd_ack_timeout: got %b expected %b", sw_rd_ack, lvl);
    end
  endtask

  task automatic sw_write(input logic [DB-1:0] a, input logic [47:0] m, input logic [NQ-1:0] q, input logic p);
    push(1, a, m, q, p);
    sw_wr_addr = a; sw_wr_mac = m; sw_wr_oq = q; sw_wr_protect = p;
    sw_wr_req = 1'b1;
    wait_wr_ack(1'b1);
    sw_wr_req = 1'b0;
    wait_wr_ack(1'b0);
    tick();
  endtask

  task automatic sw_read(input logic [DB-1:0] a, input logic [47:0] m, input logic [NQ-1:0] q, input logic p);
    push(0, a, m, q, p);
    sw_rd_addr = a;
    sw_rd_req = 1'b1;
    wait_rd_ack(1'b1);
    sw_rd_req = 1'b0;
    wait_rd_ack(1'b0);
    tick();
  endtask

  task automatic wait_rd5(input int n);
    for (int i = 0; i < 4000 && rd5_cnt < n; i++) tick();
    check("rd5_reached", 64'(rd5_cnt >= n), 64'd1);
  endtask

  task automatic quiesce();
    aging_en = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int base;
    bit wr_seen, order_ok, hit_done;
    reset = 1'b1; mem_init = 1'b1;
    sw_rd_addr = '0; sw_rd_req = 0; sw_wr_addr = '0; sw_wr_req = 0;
    sw_wr_oq = '0; sw_wr_protect = 0; sw_wr_mac = '0;
    lut_hit = 0; lut_hit_addr = '0; aging_en = 0;
    repeat (3) tick();
    mem_init = 1'b0;
    check("rst_sw_rd_ack", 64'(sw_rd_ack), 64'd0);
    check("rst_sw_wr_ack", 64'(sw_wr_ack), 64'd0);
    check("rst_lut_rd_req", 64'(lut_rd_req), 64'd0);
    check("rst_lut_wr_req", 64'(lut_wr_req), 64'd0);
    check("rst_entries_aged", 64'(entries_aged), 64'd0);
    check("rst_sw_rd_mac", 64'(sw_rd_mac), 64'd0);
    reset = 1'b0;
    tick();

    // Read priority over a pending scan.
    push(0, 4'd3, MAC3, 8'h5A, 1'b1);
    sw_rd_addr = 4'd3; sw_rd_req = 1'b1; aging_en = 1'b1;
    wait_rd_ack(1'b1);
    repeat (30) tick();
    check("prio_scan_pending", 64'(dut.scan_pending_q), 64'd1);
    check("prio_lut_rd_addr", 64'(lut_rd_addr), 64'd3);
    check("prio_no_age_read", 64'(age_rd_cnt), 64'd0);
    sw_rd_req = 1'b0;
    wait_rd_ack(1'b0);
    for (int i = 0; i < 20 && age_rd_cnt == 0; i++) tick();
    check("prio_age_read_seen", 64'(age_rd_cnt), 64'd1);
    check("prio_age_addr", 64'(last_age_addr), 64'd0);
    quiesce();

    // Simultaneous write and read: write served first.
    push(1, 4'd5, MAC5, 8'h21, 1'b0);
    push(0, 4'd5, MAC5, 8'h21, 1'b0);
    sw_wr_addr = 4'd5; sw_wr_mac = MAC5; sw_wr_oq = 8'h21; sw_wr_protect = 1'b0;
    sw_rd_addr = 4'd5;
    sw_wr_req = 1'b1; sw_rd_req = 1'b1;
    wr_seen = 0; order_ok = 1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (sw_wr_ack) begin sw_wr_req = 1'b0; wr_seen = 1; end
      if (sw_rd_ack) begin sw_rd_req = 1'b0; if (!wr_seen) order_ok = 0; end
      if (!sw_wr_req && !sw_rd_req && !sw_wr_ack && !sw_rd_ack) break;
    end
    check("simul_done", 64'({sw_wr_req, sw_rd_req}), 64'd0);
    check("simul_order", 64'(order_ok), 64'd1);
    tick();

    // Expiry of an unprotected entry after eight ageing reads.
    push(1, 4'd5, 48'h0, 8'h00, 1'b0);
    rd5_cnt = 0;
    aging_en = 1'b1;
    for (int i = 0; i < 4000 && entries_aged == 0; i++) tick();
    check("expiry_entries_aged", 64'(entries_aged), 64'd1);
    check("expiry_scan_count", 64'(rd5_cnt), 64'd8);
    check("expiry_mem_mac", 64'(lut_mem[5].mac), 64'd0);
    quiesce();
    sw_read(4'd5, 48'h0, 8'h00, 1'b0);

    // Protected entry never expires; age saturates.
    sw_write(4'd5, MAC5, 8'h21, 1'b1);
    rd5_cnt = 0;
    aging_en = 1'b1;
    wait_rd5(10);
    repeat (5) tick();
    check("protect_age_sat", 64'(dut.u_age_table.age_q[5]), 64'd7);
    check("protect_entries_aged", 64'(entries_aged), 64'd1);
    quiesce();

    // Periodic hits keep the entry alive.
    sw_write(4'd5, MAC5, 8'h21, 1'b0);
    rd5_cnt = 0;
    aging_en = 1'b1;
    lut_hit_addr = 4'd5;
    for (int c = 0; c < 4000 && rd5_cnt < 10; c++) begin
      lut_hit = (c % (3 * TC) == 0);
      tick();
    end
    lut_hit = 1'b0;
    check("hit_refresh_scans", 64'(rd5_cnt >= 10), 64'd1);
    check("hit_refresh_entries_aged", 64'(entries_aged), 64'd1);
    for (int i = 0; i < 2000 && dut.u_age_table.age_q[5] != 3'd7; i++) tick();
    check("hit_age_reached_max", 64'(dut.u_age_table.age_q[5]), 64'd7);
    hit_done = 0;
    for (int i = 0; i < 400 && !hit_done; i++) begin
      if (lut_rd_req && lut_rd_ack && lut_rd_addr == 4'd5 && !sw_rd_req) begin
        lut_hit = 1'b1;
        tick();
        lut_hit = 1'b0;
        hit_done = 1;
      end else tick();
    end
    check("hit_exact_injected", 64'(hit_done), 64'd1);
    check("hit_exact_age", 64'(dut.u_age_table.age_q[5]), 64'd0);
    repeat (5) tick();
    check("hit_exact_entries_aged", 64'(entries_aged), 64'd1);
    quiesce();

    // Disable mid-scan stops further ageing reads.
    aging_en = 1'b1;
    base = age_rd_cnt;
    for (int i = 0; i < 100 && age_rd_cnt == base; i++) tick();
    check("disable_scan_started", 64'(age_rd_cnt != base), 64'd1);
    aging_en = 1'b0;
    tick();
    check("disable_scan_pending", 64'(dut.scan_pending_q), 64'd0);
    base = age_rd_cnt;
    repeat (200) tick();
    check("disable_no_reads", 64'(age_rd_cnt - base), 64'd0);

    // Reset while an ageing write is outstanding.
    sw_write(4'd5, MAC5, 8'h21, 1'b0);
    push(1, 4'd5, 48'h0, 8'h00, 1'b0);
    aging_en = 1'b1;
    for (int i = 0; i < 4000 && !(lut_wr_req && !sw_wr_req); i++) tick();
    check("agewr_started", 64'(lut_wr_req), 64'd1);
    check("agewr_entries_before", 64'(entries_aged), 64'd1);
    reset = 1'b1;
    tick();
    check("rst_mid_lut_wr_req", 64'(lut_wr_req), 64'd0);
    check("rst_mid_lut_rd_req", 64'(lut_rd_req), 64'd0);
    check("rst_mid_lut_rd_addr", 64'(lut_rd_addr), 64'd0);
    check("rst_mid_entries_aged", 64'(entries_aged), 64'd0);
    check("rst_mid_acks", 64'({sw_rd_ack, sw_wr_ack}), 64'd0);
    aging_en = 1'b0;
    reset = 1'b0;
    repeat (5) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
